// File: rtl/dmem_pkg.sv
// Shared definitions for the multicore shared data memory.
// Build with DMEM_RR_ARB_EN defined for round-robin arbitration.
package dmem_pkg;

   localparam int DMEM_DATA_W    = 16;
   localparam int DMEM_ADDR_W    = 16;
   localparam int DMEM_DEPTH     = 1024;
   localparam int NCORES_MAX     = 8;
   localparam int DMEM_OOB_RDATA = 0;

   typedef enum logic {
      ACC_RD = 1'b0,
      ACC_WR = 1'b1
   } acc_e;

   // Never returns less than 1 so single-entry indices stay legal.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// One-grant-per-cycle arbiter for the shared data memory.
// DMEM_RR_ARB_EN selects round-robin, otherwise lowest index wins.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int NCORES = 4,
   parameter int IDXW   = clog2(NCORES)
)(
   input  logic [NCORES-1:0] req,
`ifdef DMEM_RR_ARB_EN
   input  logic [IDXW-1:0]   ptr,
`endif
   output logic [NCORES-1:0] gnt,
   output logic [IDXW-1:0]   idx
);

`ifdef DMEM_RR_ARB_EN
   logic [IDXW:0]   sum;
   logic [IDXW-1:0] j;
   logic            found;

   // Walk the ring starting at ptr, wrapping at NCORES.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      j     = '0;
      for (int i = 0; i < NCORES; i++) begin
         sum = {1'b0, ptr} + (IDXW+1)'(i);
         if (sum >= (IDXW+1)'(NCORES))
            sum = sum - (IDXW+1)'(NCORES);
         j = sum[IDXW-1:0];
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end
`else
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = NCORES - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            idx    = IDXW'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/shared_data_mem.sv
// Single-ported data array shared by NCORES load/store ports.
// DMEM_RR_ARB_EN enables round-robin arbitration (default fixed priority).
module shared_data_mem
   import dmem_pkg::*;
#(
   parameter int NCORES = 4,
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DEPTH  = DMEM_DEPTH
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NCORES-1:0]        req,
   input  logic [NCORES-1:0]        we,
   input  logic [NCORES*ADDR_W-1:0] addr,
   input  logic [NCORES*DATA_W-1:0] wdata,
   output logic [NCORES-1:0]        gnt,
   output logic [NCORES-1:0]        rvalid,
   output logic [NCORES*DATA_W-1:0] rdata,
   output logic                     oob_err
);

   localparam int IDXW = clog2(NCORES);
   localparam int MAW  = clog2(DEPTH);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

   logic [NCORES-1:0] agnt;
   logic [IDXW-1:0]   gidx;
   logic [ADDR_W-1:0] a_sel;
   logic [DATA_W-1:0] w_sel;
   logic [DATA_W-1:0] rd_word;
   logic [MAW-1:0]    ma;
   acc_e              acc;
   logic              fire;
   logic              inb;

   logic [DATA_W-1:0] mem [DEPTH];

`ifdef DMEM_RR_ARB_EN
   logic [IDXW-1:0] ptr;

   dmem_arbiter #(
      .NCORES (NCORES),
      .IDXW   (IDXW)
   ) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (agnt),
      .idx (gidx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (fire)
         ptr <= (gidx == IDXW'(NCORES - 1)) ? '0 : gidx + 1'b1;
   end
`else
   dmem_arbiter #(
      .NCORES (NCORES),
      .IDXW   (IDXW)
   ) u_arb (
      .req (req),
      .gnt (agnt),
      .idx (gidx)
   );
`endif

   assign gnt  = rst_n ? agnt : '0;
   assign fire = |gnt;

   always_comb begin
      a_sel = '0;
      w_sel = '0;
      acc   = ACC_RD;
      for (int k = 0; k < NCORES; k++) begin
         if (gidx == IDXW'(k)) begin
            a_sel = addr[k*ADDR_W +: ADDR_W];
            w_sel = wdata[k*DATA_W +: DATA_W];
            acc   = acc_e'(we[k]);
         end
      end
   end

   assign inb     = {1'b0, a_sel} < LIMIT;
   assign ma      = a_sel[MAW-1:0];
   assign rd_word = inb ? mem[ma] : DATA_W'(DMEM_OOB_RDATA);

   always_ff @(posedge clk) begin
      if (fire && inb && acc == ACC_WR)
         mem[ma] <= w_sel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid  <= '0;
         rdata   <= '0;
         oob_err <= 1'b0;
      end else begin
         rvalid  <= '0;
         oob_err <= fire & ~inb;
         if (fire && acc == ACC_RD) begin
            for (int k = 0; k < NCORES; k++) begin
               if (gidx == IDXW'(k)) begin
                  rvalid[k]                  <= 1'b1;
                  rdata[k*DATA_W +: DATA_W]  <= rd_word;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_shared_data_mem.sv
// Self-checking bench for shared_data_mem (either arbitration mode).
module tb_shared_data_mem;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 1024;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, we, gnt, rvalid;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata, rdata;
   logic            oob_err;

   always #5 clk = ~clk;

   shared_data_mem #(
      .NCORES (N),
      .DATA_W (DW),
      .ADDR_W (AW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .gnt     (gnt),
      .rvalid  (rvalid),
      .rdata   (rdata),
      .oob_err (oob_err)
   );

   int total = 0;
   int passed = 0;

   // reference model: word store, per-core read registers, arbiter pointer
   logic [DW-1:0] mm [int];
   logic [N-1:0]  m_rv;
   logic [DW-1:0] m_rd [N];
   logic          m_oob;
   int            ptr;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [N-1:0] gnt;
      logic [N-1:0] rv;
      logic         oob;
      int           core;
      logic [DW-1:0] rd;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    nm, act, exp, $time);
   endtask

   function automatic logic [N-1:0] arb(input logic [N-1:0] r, input int p);
`ifdef DMEM_RR_ARB_EN
      for (int i = 0; i < N; i++)
         if (r[(p + i) % N]) return N'(1) << ((p + i) % N);
`else
      for (int i = 0; i < N; i++)
         if (r[i]) return N'(1) << i;
`endif
      return '0;
   endfunction

   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      req = r;
      we = w;
      addr = {N{a}};
      wdata = {N{d}};
   endtask

   // applied at the posedge with the inputs that were sampled there
   task automatic model_step(input logic [N-1:0] g);
      logic [AW-1:0] a;
      m_rv = '0;
      m_oob = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (g[k]) begin
            a = addr[k*AW +: AW];
            if (int'(a) >= DEPTH) begin
               m_oob = 1'b1;
               if (!we[k]) begin
                  m_rv[k] = 1'b1;
                  m_rd[k] = '0;
               end
            end else if (we[k]) begin
               mm[int'(a)] = wdata[k*DW +: DW];
            end else begin
               m_rv[k] = 1'b1;
               m_rd[k] = mm.exists(int'(a)) ? mm[int'(a)] : 'x;
            end
            ptr = (k + 1) % N;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_gnt"}, gnt, arb(req, ptr));
      chk({tag, "_rvalid"}, rvalid, m_rv);
      chk({tag, "_oob"}, oob_err, m_oob);
      for (int k = 0; k < N; k++)
         chk({tag, "_rdata"}, rdata[k*DW +: DW], m_rd[k]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      we = '0;
      m_rv = '0;
      m_oob = 1'b0;
      ptr = 0;
      for (int k = 0; k < N; k++) m_rd[k] = '0;
      @(negedge clk);
      chk("rst_rvalid", rvalid, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   int pool [8] = '{0, 5, 16, 'h3FE, 'h3FF, 'h400, 'h123, 'hFFFF};
   logic        pend [N];
   logic        p_we [N];
   logic [AW-1:0] p_a [N];
   logic [DW-1:0] p_d [N];
   int          waitc [N];

   initial begin
      logic [N-1:0] g;

      vt[0] = '{4'b1000, 4'b1000, 16'h03FF, 16'h7777, 4'b1000, 4'b0000, 1'b0, -1, 16'h0};
      vt[1] = '{4'b0010, 4'b0010, 16'h0005, 16'hBEEF, 4'b0010, 4'b0000, 1'b0, -1, 16'h0};
      vt[2] = '{4'b0100, 4'b0000, 16'h0005, 16'h0000, 4'b0100, 4'b0000, 1'b0, -1, 16'h0};
      vt[3] = '{4'b0001, 4'b0001, 16'h0400, 16'h1234, 4'b0001, 4'b0100, 1'b0, 2, 16'hBEEF};
      vt[4] = '{4'b0001, 4'b0000, 16'h0400, 16'h0000, 4'b0001, 4'b0000, 1'b1, -1, 16'h0};
      vt[5] = '{4'b1000, 4'b0000, 16'h03FF, 16'h0000, 4'b1000, 4'b0001, 1'b1, 0, 16'h0000};
      vt[6] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b1000, 1'b0, 3, 16'h7777};
      vt[7] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1, 16'h0000};

      // reset with every core requesting
      rst_n = 1'b0;
      drive(4'b1111, 4'b0000, 16'h0, 16'h0);
      m_rv = '0;
      m_oob = 1'b0;
      ptr = 0;
      for (int k = 0; k < N; k++) m_rd[k] = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_oob", oob_err, 0);
      we = 4'b1111;
      rst_n = 1'b1;
      #1;
      chk("rel_gnt", gnt, 4'b0001);
      @(posedge clk);
      model_step(4'b0001);
      #1;
      req = '0;

      // directed single-requester table
      for (int i = 0; i < 8; i++) begin
         drive(vt[i].req, vt[i].we, vt[i].a, vt[i].d);
         @(negedge clk);
         chk("tbl_gnt", gnt, vt[i].gnt);
         chk("tbl_rvalid", rvalid, vt[i].rv);
         chk("tbl_oob", oob_err, vt[i].oob);
         if (vt[i].core >= 0)
            chk("tbl_rdata", rdata[vt[i].core*DW +: DW], vt[i].rd);
         g = arb(req, ptr);
         @(posedge clk);
         model_step(g);
         #1;
      end

      // contention
      do_reset();
`ifdef DMEM_RR_ARB_EN
      drive(4'b1111, 4'b0000, 16'h0005, 16'h0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("rr_gnt", gnt, N'(1) << (c % N));
         chk("rr_rvalid", rvalid, (c == 0) ? 0 : N'(1) << ((c - 1) % N));
         g = arb(req, ptr);
         @(posedge clk);
         model_step(g);
         #1;
      end
      req = '0;
      @(negedge clk);
      chk("rr_last_rvalid", rvalid, 4'b1000);
`else
      drive(4'b1010, 4'b0000, 16'h0005, 16'h0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("fp_gnt", gnt, 4'b0010);
         chk("fp_rvalid", rvalid, (c == 0) ? 0 : 4'b0010);
         g = arb(req, ptr);
         @(posedge clk);
         model_step(g);
         #1;
      end
      req = '0;
      @(negedge clk);
      chk("fp_rdata1", rdata[1*DW +: DW], 16'hBEEF);
`endif

      // reset arriving right after a read grant
      do_reset();
      drive(4'b1000, 4'b1000, 16'h0010, 16'hCAFE);
      @(negedge clk);
      chk("mr_wr_gnt", gnt, 4'b1000);
      @(posedge clk);
      model_step(4'b1000);
      #1;
      we = '0;
      @(negedge clk);
      chk("mr_rd_gnt", gnt, 4'b1000);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req = '0;
      @(negedge clk);
      chk("mr_rvalid_a", rvalid, 0);
      @(negedge clk);
      chk("mr_rvalid_b", rvalid, 0);
      rst_n = 1'b1;
      m_rv = '0;
      m_oob = 1'b0;
      ptr = 0;
      for (int k = 0; k < N; k++) m_rd[k] = '0;
      @(posedge clk);
      #1;
      chk("mr_rvalid_c", rvalid, 0);
      drive(4'b0001, 4'b0000, 16'h0010, 16'h0);
      @(negedge clk);
      chk("mr_re_gnt", gnt, 4'b0001);
      @(posedge clk);
      model_step(4'b0001);
      #1;
      req = '0;
      @(negedge clk);
      chk("mr_re_rvalid", rvalid, 4'b0001);
      chk("mr_re_rdata", rdata[DW-1:0], 16'hCAFE);

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < N; k++) begin
         pend[k] = 1'b0;
         waitc[k] = 0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && ($urandom % 2 == 1)) begin
               pend[k] = 1'b1;
               waitc[k] = 0;
               p_a[k] = AW'(pool[$urandom_range(0, 7)]);
               p_d[k] = DW'($urandom);
               p_we[k] = ($urandom % 2 == 1);
               if (!p_we[k] && int'(p_a[k]) < DEPTH &&
                   !mm.exists(int'(p_a[k])))
                  p_we[k] = 1'b1;
            end
            req[k] = pend[k];
            we[k] = pend[k] ? p_we[k] : 1'b0;
            addr[k*AW +: AW] = p_a[k];
            wdata[k*DW +: DW] = p_d[k];
         end
         @(negedge clk);
         check_all("rnd");
         g = arb(req, ptr);
         @(posedge clk);
         model_step(g);
         for (int k = 0; k < N; k++) begin
            if (g[k]) begin
`ifdef DMEM_RR_ARB_EN
               chk("rnd_rr_wait", waitc[k] < N, 1);
`endif
               pend[k] = 1'b0;
            end else if (pend[k]) begin
               waitc[k]++;
            end
         end
         #1;
      end
      req = '0;
      @(negedge clk);
      check_all("rnd_end");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
